// File: rtl/e203_itcm_sram_ctrl_if.sv
// ICB command/response channel plus the 64-bit single-port SRAM macro pins.
interface e203_itcm_sram_ctrl_if;
    // ICB command channel
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    // ICB response channel
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    // SRAM macro
    logic        ram_cs;
    logic        ram_we;
    logic        ram_ls;
    logic        ram_sd;
    logic        ram_ds;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wem;
    logic [63:0] ram_din;
    logic [63:0] ram_dout;

    // Controller side
    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready, ram_dout,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        output ram_cs, ram_we, ram_ls, ram_sd, ram_ds, ram_addr, ram_wem, ram_din
    );

    // Requester / SRAM model side
    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready, ram_dout,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        input  ram_cs, ram_we, ram_ls, ram_sd, ram_ds, ram_addr, ram_wem, ram_din
    );
endinterface

// File: rtl/e203_itcm_sram_ctrl.sv
// ITCM SRAM controller: ICB slave over a 64-bit SRAM, one outstanding command,
// response hold buffer for back-pressure and idle-driven light sleep.
module e203_itcm_sram_ctrl #(
    parameter int unsigned IDLE_LS_CYC  = 16,
    parameter logic [15:0] ITCM_BASE_HI = 16'h8000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    e203_itcm_sram_ctrl_if.slave          itcm_io
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRsp   = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [1:0] StSleep = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic        rd_q, hi_q, err_q;
    logic [31:0] hold_rdata_q, hold_rdata_d;
    logic        hold_err_q, hold_err_d;

    logic        cmd_ready;
    logic        cmd_hsk;
    logic        addr_err;
    logic        ram_acc;
    logic [31:0] rsp_rdata_cur;
    logic [7:0]  idle_cnt_inc;

    assign addr_err = (itcm_io.icb_cmd_addr[31:16] != ITCM_BASE_HI);
    assign cmd_hsk  = itcm_io.icb_cmd_valid & cmd_ready;
    assign ram_acc  = cmd_hsk & ~addr_err;

    // Command acceptance depends on state; RSP accepts only when its response retires
    always_comb begin
        cmd_ready = 1'b0;
        unique case (state_q)
            StIdle:  cmd_ready = 1'b1;
            StRsp:   cmd_ready = itcm_io.icb_rsp_ready;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign itcm_io.icb_cmd_ready = cmd_ready;

    // SRAM is driven straight from the command in its handshake cycle
    always_comb begin
        itcm_io.ram_cs   = ram_acc;
        itcm_io.ram_we   = ram_acc & ~itcm_io.icb_cmd_read;
        itcm_io.ram_addr = itcm_io.icb_cmd_addr[15:3];
        itcm_io.ram_din  = {itcm_io.icb_cmd_wdata, itcm_io.icb_cmd_wdata};
        itcm_io.ram_wem  = 8'h00;
        if (ram_acc && !itcm_io.icb_cmd_read) begin
            itcm_io.ram_wem = itcm_io.icb_cmd_addr[2] ? {itcm_io.icb_cmd_wmask, 4'h0}
                                                      : {4'h0, itcm_io.icb_cmd_wmask};
        end
    end

    assign itcm_io.ram_ls = (state_q == StSleep);
    assign itcm_io.ram_sd = 1'b0;
    assign itcm_io.ram_ds = 1'b0;

    // Live response data in RSP: errors and writes return zero
    assign rsp_rdata_cur = (err_q | ~rd_q) ? 32'h0 :
                           (hi_q ? itcm_io.ram_dout[63:32] : itcm_io.ram_dout[31:0]);

    // Response outputs: live SRAM data in RSP, buffered copy in HOLD
    always_comb begin
        itcm_io.icb_rsp_valid = 1'b0;
        itcm_io.icb_rsp_rdata = 32'h0;
        itcm_io.icb_rsp_err   = 1'b0;
        unique case (state_q)
            StRsp: begin
                itcm_io.icb_rsp_valid = 1'b1;
                itcm_io.icb_rsp_rdata = rsp_rdata_cur;
                itcm_io.icb_rsp_err   = err_q;
            end
            StHold: begin
                itcm_io.icb_rsp_valid = 1'b1;
                itcm_io.icb_rsp_rdata = hold_rdata_q;
                itcm_io.icb_rsp_err   = hold_err_q;
            end
            default: ;
        endcase
    end

    assign idle_cnt_inc = (idle_cnt_q == 8'hFF) ? 8'hFF : idle_cnt_q + 8'd1;

    // Next state, idle counter and hold-buffer capture
    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = 8'd0;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_hsk) begin
                    state_d = StRsp;
                end else begin
                    idle_cnt_d = idle_cnt_inc;
                    if (idle_cnt_inc >= 8'(IDLE_LS_CYC)) begin
                        state_d    = StSleep;
                        idle_cnt_d = 8'd0;
                    end
                end
            end
            StRsp: begin
                if (!itcm_io.icb_rsp_ready) begin
                    state_d      = StHold;
                    hold_rdata_d = rsp_rdata_cur;
                    hold_err_d   = err_q;
                end else if (!cmd_hsk) begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (itcm_io.icb_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                // Wake costs one cycle; the command is taken in IDLE
                if (itcm_io.icb_cmd_valid) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idle_cnt_q   <= 8'd0;
            rd_q         <= 1'b0;
            hi_q         <= 1'b0;
            err_q        <= 1'b0;
            hold_rdata_q <= 32'h0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
            if (cmd_hsk) begin
                rd_q  <= itcm_io.icb_cmd_read;
                hi_q  <= itcm_io.icb_cmd_addr[2];
                err_q <= addr_err;
            end
        end
    end

endmodule
